// File: rtl/axi_rd_responder.sv
// AXI4 read-only responder: one outstanding burst, optional response delay,
// address-derived read data with DECERR/SLVERR signalling.
module axi_rd_responder #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH = 6,
  parameter int AXI_USER_WIDTH = 8,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int SIZE_BYTES = 4096,
  parameter int RESP_DELAY = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [AXI_ID_WIDTH-1:0]   ar_id,
  input  logic [AXI_ADDR_WIDTH-1:0] ar_addr,
  input  logic [7:0]                ar_len,
  input  logic [2:0]                ar_size,
  input  logic [1:0]                ar_burst,
  input  logic [AXI_USER_WIDTH-1:0] ar_user,
  input  logic                      ar_valid,
  output logic                      ar_ready,
  output logic [AXI_ID_WIDTH-1:0]   r_id,
  output logic [AXI_DATA_WIDTH-1:0] r_data,
  output logic [1:0]                r_resp,
  output logic                      r_last,
  output logic [AXI_USER_WIDTH-1:0] r_user,
  output logic                      r_valid,
  input  logic                      r_ready
);

  localparam int AW = AXI_ADDR_WIDTH;
  localparam int MAX_SIZE = $clog2(AXI_DATA_WIDTH / 8);
  localparam int DW = (RESP_DELAY > 1) ? $clog2(RESP_DELAY) : 1;
  localparam logic [AW:0] LO = {1'b0, BASE_ADDR};
  localparam logic [AW:0] HI = LO + (AW+1)'(SIZE_BYTES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    BURST = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [AXI_ID_WIDTH-1:0]   id_q;
  logic [AXI_USER_WIDTH-1:0] user_q;
  logic [7:0]                len_q;
  logic [2:0]                size_q;
  logic [1:0]                burst_q;
  logic [AW-1:0]             addr_q;
  logic [7:0]                beat_q;
  logic [DW-1:0]             dly_q;
  logic                      err_q;

  logic          accept;
  logic          beat_done;
  logic          last_beat;
  logic          ar_err;
  logic          in_range;
  logic [AW-1:0] ar_align;
  logic [AW-1:0] inc;
  logic [AW-1:0] wmask;
  logic [AW-1:0] addr_nxt;

  assign accept    = ar_valid && ar_ready;
  assign beat_done = r_valid && r_ready;
  assign last_beat = (beat_q == len_q);

  assign ar_align = ar_addr & ~((AW'(1) << ar_size) - AW'(1));

  assign ar_err = (ar_burst == 2'b11)
               || (ar_burst == 2'b10 &&
                   !(ar_len inside {8'd1, 8'd3, 8'd7, 8'd15}))
               || (ar_size > 3'(MAX_SIZE));

  assign in_range = ({1'b0, addr_q} >= LO) && ({1'b0, addr_q} < HI);

  // wrap window is a power of two, so wrapping is a masked increment
  assign inc   = AW'(1) << size_q;
  assign wmask = ((AW'(len_q) + AW'(1)) << size_q) - AW'(1);

  always_comb begin
    addr_nxt = addr_q + inc;
    unique case (burst_q)
      2'b00:   addr_nxt = addr_q;
      2'b10:   addr_nxt = (addr_q & ~wmask) | ((addr_q + inc) & wmask);
      default: addr_nxt = addr_q + inc;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (accept)
          state_nxt = (RESP_DELAY == 0) ? BURST : DELAY;
      DELAY:
        if (dly_q == '0) state_nxt = BURST;
      BURST:
        if (beat_done && last_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ar_ready = (state == IDLE);
    r_valid  = (state == BURST);
    r_last   = r_valid && last_beat;
    r_id     = id_q;
    r_user   = user_q;
    r_resp   = 2'b00;
    r_data   = '0;
    if (r_valid) begin
      if (err_q)          r_resp = 2'b10;
      else if (!in_range) r_resp = 2'b11;
      else                r_data = {addr_q, ~addr_q};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      id_q    <= '0;
      user_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      addr_q  <= '0;
      beat_q  <= '0;
      dly_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        id_q    <= ar_id;
        user_q  <= ar_user;
        len_q   <= ar_len;
        size_q  <= ar_size;
        burst_q <= ar_burst;
        addr_q  <= ar_align;
        err_q   <= ar_err;
        beat_q  <= '0;
        dly_q   <= DW'(RESP_DELAY - 1);
      end
      if (state == DELAY && dly_q != '0)
        dly_q <= dly_q - DW'(1);
      if (beat_done) begin
        beat_q <= beat_q + 8'd1;
        addr_q <= addr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_axi_rd_responder.sv
// Bench for axi_rd_responder: two instances (RESP_DELAY 0 and 3) share
// stimulus; a burst-level model predicts every beat, plus literal pins.
module tb_axi_rd_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [5:0]  ar_id;
  logic [31:0] ar_addr;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic [7:0]  ar_user;
  logic        ar_valid;
  logic        r_ready;

  logic        arr[2];
  logic        rv[2];
  logic        rl[2];
  logic [63:0] rd[2];
  logic [1:0]  rr[2];
  logic [5:0]  ri[2];
  logic [7:0]  ru[2];

  axi_rd_responder #(.RESP_DELAY(0)) u_d0 (
    .clk_i(clk), .rst_i(rst),
    .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len),
    .ar_size(ar_size), .ar_burst(ar_burst), .ar_user(ar_user),
    .ar_valid(ar_valid), .ar_ready(arr[0]),
    .r_id(ri[0]), .r_data(rd[0]), .r_resp(rr[0]), .r_last(rl[0]),
    .r_user(ru[0]), .r_valid(rv[0]), .r_ready(r_ready)
  );

  axi_rd_responder #(.RESP_DELAY(3)) u_d3 (
    .clk_i(clk), .rst_i(rst),
    .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len),
    .ar_size(ar_size), .ar_burst(ar_burst), .ar_user(ar_user),
    .ar_valid(ar_valid), .ar_ready(arr[1]),
    .r_id(ri[1]), .r_data(rd[1]), .r_resp(rr[1]), .r_last(rl[1]),
    .r_user(ru[1]), .r_valid(rv[1]), .r_ready(r_ready)
  );

  int vectors = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // expected beats of the current burst
  logic [31:0] m_addr[256];
  logic [1:0]  m_resp[256];
  logic [63:0] m_data[256];
  logic [7:0]  m_len;
  logic [5:0]  m_id;
  logic [7:0]  m_user;

  int dly[2] = '{0, 3};
  bit act[2];
  bit just_rst[2];
  int beat[2];
  int first[2];
  int acc[2];
  int lat[2];
  int o_cnt[2];
  logic [63:0] o_data[2][256];
  logic [1:0]  o_resp[2][256];
  logic        o_last[2][256];
  logic [5:0]  o_id[2][256];

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic void build(logic [31:0] a, logic [7:0] len,
                                logic [2:0] size, logic [1:0] b);
    longint inc, start, total, bnd, x;
    bit ill;
    logic [31:0] a32;
    inc   = longint'(1) << size;
    start = (longint'(a) / inc) * inc;
    total = inc * (longint'(len) + 1);
    bnd   = (start / total) * total;
    ill   = (b == 2'b11) || (size > 3) ||
            (b == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15));
    for (int i = 0; i <= int'(len); i++) begin
      if (b == 2'b00)      x = start;
      else if (b == 2'b10) x = bnd + ((start - bnd + i * inc) % total);
      else                 x = (start + i * inc) & 64'hFFFF_FFFF;
      a32 = x[31:0];
      m_addr[i] = a32;
      if (ill) begin
        m_resp[i] = 2'b10; m_data[i] = '0;
      end else if (a32 < 32'd4096) begin
        m_resp[i] = 2'b00; m_data[i] = {a32, ~a32};
      end else begin
        m_resp[i] = 2'b11; m_data[i] = '0;
      end
    end
    m_len = len;
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit ev;
      ev = act[i] && (cyc >= first[i]);
      chk($sformatf("d%0d ar_ready", i), 64'(arr[i]), 64'(!act[i]));
      chk($sformatf("d%0d r_valid", i), 64'(rv[i]), 64'(ev));
      if (just_rst[i]) begin
        chk($sformatf("d%0d rst r_last", i), 64'(rl[i]), 0);
        chk($sformatf("d%0d rst r_resp", i), 64'(rr[i]), 0);
        chk($sformatf("d%0d rst r_data", i), rd[i], 0);
        chk($sformatf("d%0d rst r_id", i), 64'(ri[i]), 0);
        chk($sformatf("d%0d rst r_user", i), 64'(ru[i]), 0);
      end
      if (ev && rv[i]) begin
        int k;
        k = beat[i];
        chk($sformatf("d%0d b%0d r_data", i, k), rd[i], m_data[k]);
        chk($sformatf("d%0d b%0d r_resp", i, k), 64'(rr[i]), 64'(m_resp[k]));
        chk($sformatf("d%0d b%0d r_last", i, k), 64'(rl[i]),
            64'(k == int'(m_len)));
        chk($sformatf("d%0d b%0d r_id", i, k), 64'(ri[i]), 64'(m_id));
        chk($sformatf("d%0d b%0d r_user", i, k), 64'(ru[i]), 64'(m_user));
        o_data[i][k] = rd[i];
        o_resp[i][k] = rr[i];
        o_last[i][k] = rl[i];
        o_id[i][k]   = ri[i];
        if (k == 0 && lat[i] < 0) lat[i] = cyc - acc[i];
        if (!(r_ready == 1'b0 && o_cnt[i] == k + 1)) o_cnt[i] = k + 1;
      end
      just_rst[i] = 1'b0;
      if (rst) begin
        act[i] = 1'b0;
        just_rst[i] = 1'b1;
      end else if (ev && r_ready) begin
        if (beat[i] == int'(m_len)) act[i] = 1'b0;
        beat[i]++;
      end else if (!act[i] && ar_valid) begin
        act[i] = 1'b1;
        beat[i] = 0;
        acc[i] = cyc;
        first[i] = cyc + 1 + dly[i];
      end
    end
  end

  task automatic idle_wait();
    int n = 0;
    while ((act[0] || act[1]) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) begin
      vectors++; errors++;
      $display("FAIL idle timeout: got busy expected idle");
    end
  endtask

  task automatic send(logic [5:0] id, logic [31:0] a, logic [7:0] len,
                      logic [2:0] size, logic [1:0] b, logic [7:0] user);
    idle_wait();
    build(a, len, size, b);
    m_id = id;
    m_user = user;
    for (int i = 0; i < 2; i++) begin
      o_cnt[i] = 0;
      lat[i] = -1;
      for (int j = 0; j < 256; j++) begin
        o_data[i][j] = '1; o_resp[i][j] = 'x;
        o_last[i][j] = 'x; o_id[i][j] = 'x;
      end
    end
    ar_id = id; ar_addr = a; ar_len = len;
    ar_size = size; ar_burst = b; ar_user = user;
    ar_valid = 1'b1;
    @(posedge clk); #1;
    ar_valid = 1'b0;
  endtask

  logic [31:0] w35[4] = '{32'h38, 32'h20, 32'h28, 32'h30};

  initial begin
    rst = 1'b1; r_ready = 1'b1;
    ar_valid = 1'b1; ar_id = 6'h3F; ar_addr = 32'h10;
    ar_len = 8'd0; ar_size = 3'd3; ar_burst = 2'b01; ar_user = 8'hFF;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; ar_valid = 1'b0;

    send(6'd5, 32'h100, 8'd3, 3'd3, 2'b01, 8'hA5);
    idle_wait();
    chk("incr b0 data", o_data[0][0], {32'h100, ~32'h100});
    chk("incr b3 data", o_data[0][3], {32'h118, ~32'h118});
    chk("incr b3 last", 64'(o_last[0][3]), 1);
    chk("incr b2 last", 64'(o_last[0][2]), 0);
    chk("incr b3 id", 64'(o_id[0][3]), 5);
    chk("incr d0 latency", 64'(lat[0]), 1);

    send(6'd1, 32'h38, 8'd3, 3'd3, 2'b10, 8'd0);
    idle_wait();
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("wrap b%0d addr", j), 64'(o_data[0][j][63:32]),
          64'(w35[j]));
      chk($sformatf("wrap b%0d resp", j), 64'(o_resp[0][j]), 0);
    end

    send(6'd2, 32'h40, 8'd1, 3'd3, 2'b00, 8'd3);
    ar_valid = 1'b1; ar_addr = 32'h800; ar_id = 6'd9;
    @(posedge clk); #1;
    ar_valid = 1'b0;
    begin
      int n = 0;
      while (!rv[1] && n < 20) begin @(posedge clk); #1; n++; end
      if (n >= 20) begin
        vectors++; errors++;
        $display("FAIL d3 wait: got no r_valid expected r_valid");
      end
    end
    @(posedge clk); #1 r_ready = 1'b0;
    @(posedge clk); #1 r_ready = 1'b1;
    idle_wait();
    chk("fixed d3 latency", 64'(lat[1]), 4);
    chk("fixed d3 b0 addr", 64'(o_data[1][0][63:32]), 32'h40);
    chk("fixed d3 b1 addr", 64'(o_data[1][1][63:32]), 32'h40);

    send(6'd3, 32'hFF8, 8'd1, 3'd3, 2'b01, 8'd0);
    idle_wait();
    chk("edge b0 resp", 64'(o_resp[0][0]), 0);
    chk("edge b0 data", o_data[0][0], {32'hFF8, ~32'hFF8});
    chk("edge b1 resp", 64'(o_resp[0][1]), 3);
    chk("edge b1 data", o_data[0][1], 0);

    send(6'd4, 32'h200, 8'd2, 3'd3, 2'b11, 8'd0);
    idle_wait();
    for (int j = 0; j < 3; j++)
      chk($sformatf("burst11 b%0d resp", j), 64'(o_resp[0][j]), 2);
    chk("burst11 b2 data", o_data[0][2], 0);
    send(6'd4, 32'h200, 8'd2, 3'd3, 2'b10, 8'd0);
    idle_wait();
    for (int j = 0; j < 3; j++)
      chk($sformatf("wrap3 b%0d resp", j), 64'(o_resp[0][j]), 2);

    send(6'd6, 32'h105, 8'd2, 3'd2, 2'b01, 8'h11);
    for (int n = 0; n < 40 && (act[0] || act[1]); n++) begin
      r_ready = ~r_ready;
      @(posedge clk); #1;
    end
    r_ready = 1'b1;
    idle_wait();
    chk("unalign b0 addr", 64'(o_data[0][0][63:32]), 32'h104);
    chk("unalign b2 addr", 64'(o_data[1][2][63:32]), 32'h10C);

    send(6'd7, 32'h100, 8'd0, 3'd4, 2'b01, 8'd0);
    idle_wait();
    chk("size16 resp", 64'(o_resp[0][0]), 2);
    chk("size16 last", 64'(o_last[0][0]), 1);

    send(6'd8, 32'h1C, 8'd7, 3'd2, 2'b10, 8'd0);
    idle_wait();
    chk("wrap8 b1 addr", 64'(o_data[0][1][63:32]), 32'h0);
    chk("wrap8 b7 addr", 64'(o_data[0][7][63:32]), 32'h18);

    send(6'd9, 32'hFFFF_FFF8, 8'd1, 3'd3, 2'b01, 8'd0);
    idle_wait();
    chk("roll b0 resp", 64'(o_resp[0][0]), 3);
    chk("roll b1 data", o_data[0][1], 64'h0000_0000_FFFF_FFFF);

    send(6'd10, 32'h300, 8'd7, 3'd3, 2'b01, 8'd9);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("rst d0 beats", 64'(o_cnt[0]), 2);
    chk("rst d3 beats", 64'(o_cnt[1]), 0);

    send(6'd11, 32'h80, 8'd1, 3'd3, 2'b01, 8'd0);
    idle_wait();
    chk("post rst b1 addr", 64'(o_data[0][1][63:32]), 32'h88);
    chk("post rst d3 b1", 64'(o_data[1][1][63:32]), 32'h88);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
